// File: rtl/dot_accumulate.sv
// Sums LENGTH consecutive unsigned products into one dot-product term, result on a valid/ready port.
// Latency: sum_valid rises 1 cycle after the LENGTH-th transfer. Backpressure: prod_ready low while a sum is held.
// Optional SATURATE_EN: clamp the accumulator at 2^ACCWIDTH-1 and raise a sticky overflow flag.
module dot_accumulate #(
  parameter int INWIDTH  = 8,
  parameter int OUTWIDTH = 2*INWIDTH,
  parameter int LENGTH   = 4,
  parameter int ACCWIDTH = OUTWIDTH + $clog2(LENGTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         prod_valid,
  output logic                         prod_ready,
  input  logic [OUTWIDTH-1:0]          prod,
  output logic                         sum_valid,
  input  logic                         sum_ready,
  output logic [ACCWIDTH-1:0]          sum,
  output logic [$clog2(LENGTH+1)-1:0]  term_count,
  output logic                         overflow
);

  localparam int CNTW = $clog2(LENGTH+1);
  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(LENGTH-1);

  logic [0:0]          state_q, state_d;
  logic [ACCWIDTH-1:0] acc_q, acc_d;
  logic [ACCWIDTH-1:0] sum_q, sum_d;
  logic [CNTW-1:0]     term_count_q, term_count_d;
  logic [ACCWIDTH-1:0] add_res;
  logic                add_ovf;

  assign prod_ready = (state_q == ST_ACCUM);
  assign sum_valid  = (state_q == ST_HOLD);
  assign sum        = sum_q;
  assign term_count = term_count_q;

`ifdef SATURATE_EN
  // One spare bit above the wider operand so the true sum is never lost before the compare.
  localparam int SUMW = ((ACCWIDTH > OUTWIDTH) ? ACCWIDTH : OUTWIDTH) + 1;
  localparam logic [SUMW-1:0] ACC_MAX = SUMW'({ACCWIDTH{1'b1}});

  logic [SUMW-1:0] add_full;
  logic            overflow_q, overflow_d;

  always_comb begin
    add_full = SUMW'(acc_q) + SUMW'(prod);
    add_ovf  = (add_full > ACC_MAX);
    add_res  = add_ovf ? {ACCWIDTH{1'b1}} : add_full[ACCWIDTH-1:0];
  end

  always_comb begin
    overflow_d = overflow_q;
    if (!clear && prod_valid && prod_ready && add_ovf) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  always_comb begin
    add_res = acc_q + ACCWIDTH'(prod);
    add_ovf = 1'b0;
  end

  assign overflow = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    sum_d        = sum_q;
    term_count_d = term_count_q;
    if (clear) begin
      // Abort wins over both handshakes: the presented product and any held sum are dropped.
      state_d      = ST_ACCUM;
      acc_d        = '0;
      term_count_d = '0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (prod_valid) begin
            if (term_count_q == LAST_CNT) begin
              sum_d        = add_res;
              acc_d        = '0;
              term_count_d = '0;
              state_d      = ST_HOLD;
            end else begin
              acc_d        = add_res;
              term_count_d = term_count_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (sum_ready) begin
            state_d = ST_ACCUM;
          end
        end
        default: begin
          state_d = ST_ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACCUM;
      acc_q        <= '0;
      sum_q        <= '0;
      term_count_q <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      sum_q        <= sum_d;
      term_count_q <= term_count_d;
    end
  end

endmodule
